// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_NOP0  = 3'b110,
        MD_NOP1  = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/sign_fixup.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
module sign_fixup #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one result bit per cycle.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO written here
// RUN   | one shift-add / restoring-divide step per cycle
// FIX   | apply result signs, commit HI/LO, pulse done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   addend;
    logic               is_div, neg_res, neg_rem, dz;

    logic               is_signed, neg_a, neg_b, op_is_div, op_is_md;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign op_is_md  = (op == MD_MULT) || (op == MD_MULTU) || op_is_div;
    assign neg_a     = is_signed & src_a[WIDTH-1];
    assign neg_b     = is_signed & src_b[WIDTH-1];

    sign_fixup #(.WIDTH(WIDTH)) u_abs_a (.neg(neg_a), .din(src_a), .dout(abs_a));
    sign_fixup #(.WIDTH(WIDTH)) u_abs_b (.neg(neg_b), .din(src_b), .dout(abs_b));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; a borrow out of the trial subtract means restore.
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, addend};
    assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    sign_fixup #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_res), .din(acc), .dout(prod_fix));
    sign_fixup #(.WIDTH(WIDTH)) u_fix_quot (.neg(neg_res), .din(acc[WIDTH-1:0]), .dout(quot_fix));
    sign_fixup #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_rem), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem_fix));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            addend      <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (cancel) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && op_is_md) begin
                            state   <= ST_RUN;
                            busy    <= 1'b1;
                            cnt     <= CNT_INIT;
                            is_div  <= op_is_div;
                            neg_res <= neg_a ^ neg_b;
                            neg_rem <= neg_a;
                            dz      <= op_is_div && (src_b == '0);
                            addend  <= op_is_div ? abs_b : abs_a;
                            acc     <= {{WIDTH{1'b0}}, (op_is_div ? abs_a : abs_b)};
                        end else if (start && op == MD_MTHI) begin
                            hi <= src_a;
                        end else if (start && op == MD_MTLO) begin
                            lo <= src_a;
                        end
                    end
                    ST_RUN: begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= ST_FIX;
                    end
                    ST_FIX: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (dz) begin
                            div_by_zero <= 1'b1;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at launch, compared on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    md_op_t      op = MD_NOP0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model_hi = '0, model_lo = '0;
    int          n_checks = 0, n_errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        e.hi = model_hi;
        e.lo = model_lo;
        e.dz = 1'b0;
        case (o)
            MD_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MD_DIV: begin
                if (b == 0) e.dz = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
            MD_DIVU: begin
                if (b == 0) e.dz = 1'b1;
                else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Caller is positioned at a negedge; start is sampled at the next posedge (E0).
    task automatic launch(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        op = o; src_a = a; src_b = b; start = 1'b1;
        if (o inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
            e = model(o, a, b);
            sbq.push_back(e);
            if (!e.dz) begin
                model_hi = e.hi;
                model_lo = e.lo;
            end
        end else if (o == MD_MTHI) model_hi = a;
        else if (o == MD_MTLO) model_lo = a;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; n counts negedges after E0.
    task automatic wait_done(input string tag, output int n, output bit busy_gap);
        n = 0;
        busy_gap = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!busy) busy_gap = 1'b1;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) check("spurious_done", 1, 0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
                check("sb_dz", div_by_zero, e.dz);
                check("sb_busy_low", busy, 0);
            end
        end
    end

    initial begin
        int  n;
        bit  gap;
        int  dones;
        logic [31:0] ra, rb;

        #12;
        @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", n, gap);
        check("multu_latency", n, 34);
        check("multu_busy_gap", gap, 0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        launch(MD_MULT, -32'sd3, 32'd7);
        wait_done("mult_neg", n, gap);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        launch(MD_MULT, 32'd2, 32'd3);          // issued in the done cycle
        wait_done("b2b", n, gap);
        check("b2b_latency", n, 34);
        check("b2b_lo", lo, 6);
        check("b2b_hi", hi, 0);

        @(negedge clk);
        launch(MD_DIV, -32'sd7, 32'd2);
        wait_done("div_neg", n, gap);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        launch(MD_DIVU, 32'd7, 32'd2);
        wait_done("divu", n, gap);
        check("divu_lo", lo, 3);
        check("divu_hi", hi, 1);

        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", n, gap);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 0);
        check("div_ovf_dz", div_by_zero, 0);

        @(negedge clk);
        launch(MD_MTHI, 32'h1234, 0);
        @(negedge clk);
        launch(MD_MTLO, 32'h1234, 0);
        @(negedge clk);
        launch(MD_DIVU, 32'd5, 32'd0);
        wait_done("div0", n, gap);
        check("div0_latency", n, 34);
        check("div0_flag", div_by_zero, 1);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'h1234);
        @(negedge clk);
        check("div0_flag_pulse", div_by_zero, 0);

        launch(MD_MTHI, 32'hCAFE, 0);
        check("mthi_hi", hi, 32'hCAFE);
        check("mthi_done", done, 0);
        check("mthi_busy", busy, 0);
        @(negedge clk);
        check("mthi_done_next", done, 0);

        launch(MD_DIVU, 32'd100, 32'd9);
        repeat (3) @(negedge clk);
        op = MD_MULTU; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", n, gap);
        check("busy_start_lo", lo, 11);
        @(negedge clk);
        check("busy_start_ignored", busy, 0);

        launch(MD_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        sbq.delete(sbq.size() - 1);
        model_hi = 32'h0000_0001;        // values committed by DIVU 100/9
        model_lo = 32'h0000_000B;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("cancel_no_done", dones, 0);
        check("cancel_hi", hi, model_hi);
        check("cancel_lo", lo, model_lo);

        cancel = 1'b1;
        launch(MD_MTHI, 32'hBEEF, 0);
        cancel = 1'b0;
        model_hi = 32'h0000_0001;
        check("cancel_beats_start", hi, 32'h0000_0001);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra = $urandom;
            rb = (i % 3 == 0) ? $urandom_range(1, 17) : $urandom;
            launch(md_op_t'(3'($urandom_range(0, 3))), ra, rb);
            wait_done("rand", n, gap);
            check("rand_latency", n, 34);
        end

        @(negedge clk);
        launch(MD_MULT, 32'd11, 32'd13);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("amid_hi", hi, 0);
        check("amid_lo", lo, 0);
        check("amid_busy", busy, 0);
        check("amid_done", done, 0);
        sbq.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(MD_MULTU, 32'd3, 32'd4);
        wait_done("post_rst", n, gap);
        check("post_rst_lo", lo, 12);
        check("post_rst_hi", hi, 0);

        @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
